// File: rtl/hack_mem_ctrl_if.sv
// Bus bundle between the Hack CPU memory port, the data/screen BRAM, the keyboard and the display engine.
// The ERR signal exists only when HACK_MEM_ERR_EN is defined.
interface hack_mem_ctrl_if;
  logic        STROBE;
  logic        LOAD_M;
  logic [15:0] ADDRESS_M;
  logic [15:0] OUT_M;
  logic [15:0] IN_M;
  logic        STALL;
  logic [14:0] RAM_ADDR;
  logic [15:0] RAM_WDATA;
  logic        RAM_WE;
  logic [15:0] RAM_RDATA;
  logic        KBD_VALID;
  logic        KBD_RELEASE;
  logic [15:0] KBD_CODE;
  logic        SCR_VALID;
  logic        SCR_READY;
  logic [12:0] SCR_ADDR;
  logic [15:0] SCR_DATA;
  logic        OVERFLOW;
`ifdef HACK_MEM_ERR_EN
  logic        ERR;
`endif

  modport slave (
    input  STROBE, LOAD_M, ADDRESS_M, OUT_M, RAM_RDATA,
    input  KBD_VALID, KBD_RELEASE, KBD_CODE, SCR_READY,
    output IN_M, STALL, RAM_ADDR, RAM_WDATA, RAM_WE,
    output SCR_VALID, SCR_ADDR, SCR_DATA, OVERFLOW
`ifdef HACK_MEM_ERR_EN
    , output ERR
`endif
  );

  modport master (
    output STROBE, LOAD_M, ADDRESS_M, OUT_M, RAM_RDATA,
    output KBD_VALID, KBD_RELEASE, KBD_CODE, SCR_READY,
    input  IN_M, STALL, RAM_ADDR, RAM_WDATA, RAM_WE,
    input  SCR_VALID, SCR_ADDR, SCR_DATA, OVERFLOW
`ifdef HACK_MEM_ERR_EN
    , input ERR
`endif
  );
endinterface

// File: rtl/hack_mem_ctrl.sv
// Hack memory-map controller: RAM/screen BRAM access, keyboard register, screen-write FIFO to the display.
// Define HACK_MEM_ERR_EN to add the sticky ERR output for accesses beyond the keyboard register.
module hack_mem_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] KBD_ADDR   = 16'h6000
) (
  input  logic           CLK_100MHz,
  input  logic           RESET_N,
  hack_mem_ctrl_if.slave bus
);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [1:0]  SEL_ZERO = 2'd0;
  localparam logic [1:0]  SEL_RAM  = 2'd1;
  localparam logic [1:0]  SEL_KBD  = 2'd2;

  logic        strobe_q;
  logic        step_s, wr_s, below_kbd_s, in_scr_s;
  logic        ram_we_q;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] kbd_q, kbd_d;
  logic [15:0] in_m_s;
  logic        ovf_q;
  logic        stall_q;
  logic [28:0] fifo_mem_q [FIFO_DEPTH];
  logic [28:0] head_s;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        empty_s, full_s, full_d_s, pop_s, push_s, drop_s;

  // A held strobe is one CPU step: only its first cycle qualifies.
  assign step_s      = bus.STROBE & ~strobe_q;
  assign wr_s        = step_s & bus.LOAD_M;
  assign below_kbd_s = (bus.ADDRESS_M < 16'h6000);
  assign in_scr_s    = (bus.ADDRESS_M >= 16'h4000) & below_kbd_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = ~empty_s & bus.SCR_READY;
  assign push_s  = wr_s & in_scr_s & (~full_s | pop_s);
  assign drop_s  = wr_s & in_scr_s & full_s & ~pop_s;
  assign head_s  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // FIFO pointer next-state and the full flag that drives STALL.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    full_d_s = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Read select is chosen one cycle ahead so it lines up with the BRAM read latency.
  always_comb begin
    sel_d = SEL_ZERO;
    if (below_kbd_s) begin
      sel_d = SEL_RAM;
    end else if (bus.ADDRESS_M == KBD_ADDR) begin
      sel_d = SEL_KBD;
    end else begin
      sel_d = SEL_ZERO;
    end
  end

  // Keyboard register next state; a press in the same cycle as a release wins.
  always_comb begin
    kbd_d = kbd_q;
    if (bus.KBD_VALID) begin
      kbd_d = bus.KBD_CODE;
    end else if (bus.KBD_RELEASE) begin
      kbd_d = 16'h0000;
    end else begin
      kbd_d = kbd_q;
    end
  end

  // Read data mux driven entirely from registered sources.
  always_comb begin
    in_m_s = 16'h0000;
    case (sel_q)
      SEL_RAM: in_m_s = bus.RAM_RDATA;
      SEL_KBD: in_m_s = kbd_q;
      default: in_m_s = 16'h0000;
    endcase
  end

  // Control state; reset discards every queued screen write.
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      strobe_q <= 1'b0;
      ram_we_q <= 1'b0;
      sel_q    <= SEL_ZERO;
      kbd_q    <= 16'h0000;
      ovf_q    <= 1'b0;
      stall_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      strobe_q <= bus.STROBE;
      ram_we_q <= wr_s & below_kbd_s;
      sel_q    <= sel_d;
      kbd_q    <= kbd_d;
      ovf_q    <= ovf_q | drop_s;
      stall_q  <= full_d_s;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO payload storage needs no reset: the pointers qualify it.
  always_ff @(posedge CLK_100MHz) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.ADDRESS_M[12:0], bus.OUT_M};
    end
  end

`ifdef HACK_MEM_ERR_EN
  logic err_q;

  // Sticky flag for writes at/above the keyboard or any step beyond it.
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (wr_s & ~below_kbd_s) | (step_s & (bus.ADDRESS_M > 16'h6000));
    end
  end

  assign bus.ERR = err_q;
`endif

  assign bus.IN_M      = in_m_s;
  assign bus.STALL     = stall_q;
  assign bus.RAM_ADDR  = bus.ADDRESS_M[14:0];
  assign bus.RAM_WDATA = bus.OUT_M;
  assign bus.RAM_WE    = ram_we_q;
  assign bus.SCR_VALID = ~empty_s;
  assign bus.SCR_ADDR  = head_s[28:16];
  assign bus.SCR_DATA  = head_s[15:0];
  assign bus.OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_hack_mem_ctrl.sv
// Bench for hack_mem_ctrl: directed scenarios plus randomized CPU steps against a queue/array reference model.
// A read-first sync BRAM model sits on the RAM port.
module tb_hack_mem_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hack_mem_ctrl_if bus();

  hack_mem_ctrl #(.FIFO_DEPTH(DEPTH), .KBD_ADDR(16'h6000)) dut (
    .CLK_100MHz(clk),
    .RESET_N   (rst_n),
    .bus       (bus)
  );

  logic [15:0] bram [32768] = '{default: 16'h0000};
  always @(posedge clk) begin
    bus.RAM_RDATA <= bram[bus.RAM_ADDR];
    if (bus.RAM_WE) bram[bus.RAM_ADDR] <= bus.RAM_WDATA;
  end

  // Reference model state
  logic [28:0] mq[$];
  logic [15:0] mmem [32768];
  logic [15:0] m_kbd, m_inm, m_pdata;
  logic [14:0] m_paddr;
  bit m_prev_stb, m_ovf, m_err, m_pwe;

  int n_vec = 0;
  int n_err = 0;
  bit rand_side = 1'b0;
  int unsigned ready_pct = 50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_kbd = 16'h0000; m_inm = 16'h0000;
    m_prev_stb = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_pwe = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("scr_valid", 32'(bus.SCR_VALID), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("scr_addr", 32'(bus.SCR_ADDR), 32'(mq[0][28:16]));
      check_eq("scr_data", 32'(bus.SCR_DATA), 32'(mq[0][15:0]));
    end
    check_eq("stall", 32'(bus.STALL), 32'(mq.size() == DEPTH));
    check_eq("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
    check_eq("ram_we", 32'(bus.RAM_WE), 32'(m_pwe));
    check_eq("in_m", 32'(bus.IN_M), 32'(m_inm));
`ifdef HACK_MEM_ERR_EN
    check_eq("err", 32'(bus.ERR), 32'(m_err));
`endif
  endtask

  // One clock: predict from the inputs present before the edge, then compare just after it.
  task automatic step();
    logic [15:0] a, rd;
    bit ev, wr, pop;
    a   = bus.ADDRESS_M;
    ev  = bus.STROBE && !m_prev_stb;
    wr  = ev && bus.LOAD_M;
    pop = (mq.size() != 0) && bus.SCR_READY;
    rd  = mmem[a[14:0]];
    if (m_pwe) mmem[m_paddr] = m_pdata;
    m_pwe   = wr && (a < 16'h6000);
    m_paddr = a[14:0];
    m_pdata = bus.OUT_M;
    if (pop) void'(mq.pop_front());
    if (wr && a >= 16'h4000 && a < 16'h6000) begin
      if (mq.size() < DEPTH) mq.push_back({a[12:0], bus.OUT_M});
      else m_ovf = 1'b1;
    end
    if (bus.KBD_VALID) m_kbd = bus.KBD_CODE;
    else if (bus.KBD_RELEASE) m_kbd = 16'h0000;
    if (a < 16'h6000) m_inm = rd;
    else if (a == 16'h6000) m_inm = m_kbd;
    else m_inm = 16'h0000;
    if ((wr && a >= 16'h6000) || (ev && a > 16'h6000)) m_err = 1'b1;
    m_prev_stb = bus.STROBE;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive_side();
    if (rand_side) begin
      bus.SCR_READY   = ($urandom_range(0, 99) < ready_pct);
      bus.KBD_VALID   = ($urandom_range(0, 9) == 0);
      bus.KBD_RELEASE = ($urandom_range(0, 9) == 0);
      bus.KBD_CODE    = 16'($urandom);
    end
  endtask

  task automatic cpu_op(input logic [15:0] a, input logic [15:0] d, input bit ld,
                        input int hold, input int idle);
    bus.ADDRESS_M = a; bus.OUT_M = d; bus.LOAD_M = ld; bus.STROBE = 1'b1;
    repeat (hold) begin drive_side(); step(); end
    bus.STROBE = 1'b0;
    bus.LOAD_M = 1'($urandom_range(0, 1));
    repeat (idle) begin drive_side(); step(); end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.STROBE = 1'b0;
    #1;
    check_eq("rst_scr_valid", 32'(bus.SCR_VALID), 32'd0);
    check_eq("rst_stall", 32'(bus.STALL), 32'd0);
    check_eq("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
    check_eq("rst_ram_we", 32'(bus.RAM_WE), 32'd0);
    check_eq("rst_in_m", 32'(bus.IN_M), 32'd0);
`ifdef HACK_MEM_ERR_EN
    check_eq("rst_err", 32'(bus.ERR), 32'd0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1:    return 16'($urandom_range(0, 15));
      2:       return 16'h3FF0 + 16'($urandom_range(0, 15));
      3, 4:    return 16'h4000 + 16'($urandom_range(0, 15));
      5:       return 16'h5FF0 + 16'($urandom_range(0, 15));
      6:       return 16'h6000;
      default: return 16'($urandom_range(32'h6001, 32'hFFFF));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) mmem[i] = 16'h0000;
    model_reset();
    m_paddr = 15'h0000; m_pdata = 16'h0000;
    rst_n = 1'b0;
    bus.STROBE = 1'b0; bus.LOAD_M = 1'b0; bus.ADDRESS_M = 16'h0000; bus.OUT_M = 16'h0000;
    bus.KBD_VALID = 1'b0; bus.KBD_RELEASE = 1'b0; bus.KBD_CODE = 16'h0000; bus.SCR_READY = 1'b0;
    #12;
    check_outputs();
    rst_n = 1'b1;

    // RAM write then read-back
    cpu_op(16'h0010, 16'h1234, 1'b1, 1, 1);
    check_eq("ram_no_scr", 32'(bus.SCR_VALID), 32'd0);
    cpu_op(16'h0010, 16'h0000, 1'b0, 1, 2);
    check_eq("rd_0010", 32'(bus.IN_M), 32'h1234);

    // Screen write held at the head until accepted
    bus.SCR_READY = 1'b0;
    cpu_op(16'h4005, 16'hFFFF, 1'b1, 1, 2);
    check_eq("scr_hold_valid", 32'(bus.SCR_VALID), 32'd1);
    check_eq("scr_hold_addr", 32'(bus.SCR_ADDR), 32'h005);
    check_eq("scr_hold_data", 32'(bus.SCR_DATA), 32'hFFFF);
    bus.SCR_READY = 1'b1;
    step();
    check_eq("scr_popped", 32'(bus.SCR_VALID), 32'd0);

    // Fill, then push with a same-cycle pop, then overflow
    bus.SCR_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) cpu_op(16'h4100 + 16'(i), 16'(i * 3 + 1), 1'b1, 1, 1);
    check_eq("full_stall", 32'(bus.STALL), 32'd1);
    bus.ADDRESS_M = 16'h4200; bus.OUT_M = 16'hBEEF; bus.LOAD_M = 1'b1; bus.STROBE = 1'b1;
    bus.SCR_READY = 1'b1;
    step();
    bus.STROBE = 1'b0; bus.SCR_READY = 1'b0;
    step();
    check_eq("pop_push_no_ovf", 32'(bus.OVERFLOW), 32'd0);
    check_eq("pop_push_full", 32'(bus.STALL), 32'd1);
    cpu_op(16'h4201, 16'hDEAD, 1'b1, 1, 1);
    check_eq("drop_ovf", 32'(bus.OVERFLOW), 32'd1);

    // Keyboard register
    bus.KBD_VALID = 1'b1; bus.KBD_CODE = 16'h0080;
    cpu_op(16'h6000, 16'h0000, 1'b0, 1, 1);
    bus.KBD_VALID = 1'b0;
    step();
    check_eq("kbd_press", 32'(bus.IN_M), 32'h0080);
    bus.KBD_VALID = 1'b1; bus.KBD_RELEASE = 1'b1; bus.KBD_CODE = 16'h0041;
    step();
    check_eq("kbd_both", 32'(bus.IN_M), 32'h0041);
    bus.KBD_VALID = 1'b0;
    step();
    check_eq("kbd_release", 32'(bus.IN_M), 32'h0000);
    bus.KBD_RELEASE = 1'b0;

    // Writes above the screen are ignored
    bus.SCR_READY = 1'b1;
    repeat (DEPTH + 2) step();
    cpu_op(16'h6000, 16'hAAAA, 1'b1, 1, 1);
    cpu_op(16'h7000, 16'h5555, 1'b1, 1, 1);
    check_eq("hi_no_push", 32'(bus.SCR_VALID), 32'd0);
`ifdef HACK_MEM_ERR_EN
    check_eq("hi_err", 32'(bus.ERR), 32'd1);
`endif

    // Reset with queued entries
    bus.SCR_READY = 1'b0;
    for (int i = 0; i < 3; i++) cpu_op(16'h4300 + 16'(i), 16'h0F00 + 16'(i), 1'b1, 1, 1);
    check_eq("queued3", 32'(bus.SCR_VALID), 32'd1);
    apply_reset();
    bus.SCR_READY = 1'b1;
    step();
    check_eq("post_rst_empty", 32'(bus.SCR_VALID), 32'd0);

    // Randomized CPU steps with varying display back-pressure
    rand_side = 1'b1;
    for (int op = 0; op < 600; op++) begin
      case (op / 100)
        0:       ready_pct = 5;
        1:       ready_pct = 25;
        2:       ready_pct = 60;
        3:       ready_pct = 95;
        4:       ready_pct = 0;
        default: ready_pct = 40;
      endcase
      if (op == 450) apply_reset();
      cpu_op(rand_addr(), 16'($urandom), 1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0) ? 2 : 1, int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
